// File: rtl/simmem_delay_releaser.sv
// rtl/simmem_delay_releaser.sv - per-ID delayed release credits feeding the response bank release_en
// Optional feature: SIMMEM_RELEASER_ZERO_DELAY_BYPASS_EN (zero-delay requests credit immediately).
module simmem_delay_releaser #(
  parameter int IDWidth     = 8,
  parameter int NumSlots    = 8,
  parameter int DelayWidth  = 6,
  parameter int CreditWidth = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            req_valid_i,
  output logic                            req_ready_o,
  input  logic [IDWidth-1:0]              req_id_i,
  input  logic [DelayWidth-1:0]           req_delay_i,
  input  logic                            rsp_done_i,
  input  logic [IDWidth-1:0]              rsp_id_i,
  output logic [2**IDWidth-1:0]           release_en_o,
  output logic [$clog2(NumSlots+1)-1:0]   pending_o
);

  localparam int NumIds = 2**IDWidth;
  localparam int PendW  = $clog2(NumSlots+1);
  localparam int SlotW  = (NumSlots > 1) ? $clog2(NumSlots) : 1;
  localparam int IncW   = $clog2(NumSlots+2);
  localparam int SumW   = ((CreditWidth > IncW) ? CreditWidth : IncW) + 1;
  localparam logic [CreditWidth-1:0] CredMax = '1;

  logic [NumSlots-1:0]   valid_q, valid_d;
  logic [IDWidth-1:0]    id_q    [NumSlots];
  logic [IDWidth-1:0]    id_d    [NumSlots];
  logic [DelayWidth-1:0] cnt_q   [NumSlots];
  logic [DelayWidth-1:0] cnt_d   [NumSlots];
  logic [CreditWidth-1:0] credit_q [NumIds];
  logic [CreditWidth-1:0] credit_d [NumIds];
  logic [PendW-1:0]      pending_q, pending_d;

  logic [NumSlots-1:0]   expire;
  logic [SlotW-1:0]      alloc_idx;
  logic                  accept;
  logic                  is_bypass;

  // Readiness looks only at registered valid, so an expiring slot is reusable next cycle.
  assign req_ready_o = ~&valid_q;
  assign accept      = req_valid_i && req_ready_o;
  assign pending_o   = pending_q;

`ifdef SIMMEM_RELEASER_ZERO_DELAY_BYPASS_EN
  assign is_bypass = (req_delay_i == '0);
`else
  assign is_bypass = 1'b0;
`endif

  always_comb begin
    alloc_idx = '0;
    for (int s = NumSlots-1; s >= 0; s--) begin
      if (!valid_q[s]) alloc_idx = SlotW'(s);
    end
  end

  always_comb begin
    pending_d = '0;
    for (int s = 0; s < NumSlots; s++) begin
      expire[s] = valid_q[s] && (cnt_q[s] == DelayWidth'(1));
      valid_d[s] = valid_q[s] && !expire[s];
      id_d[s]    = id_q[s];
      cnt_d[s]   = cnt_q[s];
      if (valid_q[s] && cnt_q[s] > DelayWidth'(1)) cnt_d[s] = cnt_q[s] - DelayWidth'(1);
      if (accept && !is_bypass && alloc_idx == SlotW'(s)) begin
        valid_d[s] = 1'b1;
        id_d[s]    = req_id_i;
        cnt_d[s]   = (req_delay_i == '0) ? DelayWidth'(1) : req_delay_i;
      end
      pending_d = pending_d + PendW'(valid_d[s]);
    end
  end

  function automatic logic [CreditWidth-1:0] credit_next(input int i);
    logic [IncW-1:0] inc;
    logic [SumW-1:0] sum;
    inc = '0;
    for (int s = 0; s < NumSlots; s++) begin
      if (expire[s] && id_q[s] == IDWidth'(i)) inc = inc + IncW'(1);
    end
    if (accept && is_bypass && req_id_i == IDWidth'(i)) inc = inc + IncW'(1);
    sum = SumW'(credit_q[i]) + SumW'(inc);
    // A done on a zero-credit ID is a protocol error and is dropped.
    if (rsp_done_i && rsp_id_i == IDWidth'(i) && credit_q[i] != '0) sum = sum - SumW'(1);
    credit_next = (sum > SumW'(CredMax)) ? CredMax : sum[CreditWidth-1:0];
  endfunction

  always_comb begin
    for (int i = 0; i < NumIds; i++) credit_d[i] = credit_next(i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q   <= '0;
      pending_q <= '0;
      for (int s = 0; s < NumSlots; s++) begin
        id_q[s]  <= '0;
        cnt_q[s] <= '0;
      end
      for (int i = 0; i < NumIds; i++) credit_q[i] <= '0;
    end else begin
      valid_q   <= valid_d;
      pending_q <= pending_d;
      for (int s = 0; s < NumSlots; s++) begin
        id_q[s]  <= id_d[s];
        cnt_q[s] <= cnt_d[s];
      end
      for (int i = 0; i < NumIds; i++) credit_q[i] <= credit_d[i];
    end
  end

  for (genvar g = 0; g < NumIds; g++) begin : g_rel
    assign release_en_o[g] = (credit_q[g] != '0);
  end

endmodule
